// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared external 4-bit ALU: arbitrates, registers operands, returns tagged results.
// Define ALU_ARB_FIXED_PRI_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req0_cin,
    input  logic [2:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic       req1_cin,
    input  logic [2:0] req1_op,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_result,
    output logic       rsp_cout,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_cin,
    output logic [2:0] alu_ctrl,
    input  logic [3:0] alu_out,
    input  logic       alu_cout
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state, state_nxt;
    logic   last;
    logic   grant0, grant1;

`ifdef ALU_ARB_FIXED_PRI_EN
    assign grant0 = req0_valid;
    assign grant1 = req1_valid & ~req0_valid;
`else
    // On a tie the requester that was not served most recently wins.
    assign grant0 = req0_valid & (~req1_valid | last);
    assign grant1 = req1_valid & (~req0_valid | ~last);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture on accept, result capture at the end of the EXEC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_cin    <= 1'b0;
            alu_ctrl   <= 3'd0;
            rsp_id     <= 1'b0;
            rsp_result <= 4'd0;
            rsp_cout   <= 1'b0;
            last       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0) begin
                        alu_a    <= req0_a;
                        alu_b    <= req0_b;
                        alu_cin  <= req0_cin;
                        alu_ctrl <= req0_op;
                        rsp_id   <= 1'b0;
                        last     <= 1'b0;
                    end else if (grant1) begin
                        alu_a    <= req1_a;
                        alu_b    <= req1_b;
                        alu_cin  <= req1_cin;
                        alu_ctrl <= req1_op;
                        rsp_id   <= 1'b1;
                        last     <= 1'b1;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_out;
                    // Only add (000) and subtract (001) produce a meaningful carry.
                    rsp_cout   <= (alu_ctrl[2:1] == 2'b00) ? alu_cout : 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
